branch_resolve_unit: RTL and testbench

Resolves conditional branches in ID and produces the misprediction signal that trains the IF-stage 2-bit branch predictor. Captures each IF-stage branch's prediction, PC, instruction size and predicted target, then compares rs1/rs2 in ID. On a mismatch it asserts `PreWrong`, flushes the wrong-path instruction and supplies the recovery PC. Keeps saturating branch and mispredict counters for performance monitoring.

---
 rtl/branch_resolve_unit.sv | 128 ++++++++++++
 tb/tb_branch_resolve_unit.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
//   Resolves the conditional branch sitting in ID against the prediction made
//   for it in IF. A wrong prediction raises PreWrong (trains the 2-bit
//   predictor), bubbles the wrong-path IF instruction and supplies the
//   recovery PC. Saturating counters track resolved branches and mispredicts.
//
// Ports
//   clk, rst_n            clock, async active-low reset
//   stall                 freezes all state, gates PreWrong/flush
//   ext_flush             external flush of the IF instruction (stall=0 only)
//   if_B, if_BrPre        IF instr is a branch / its prediction (1 = taken)
//   if_pc, if_rvc         IF PC and compressed flag
//   if_target             IF-computed branch target
//   id_funct3             branch condition of the ID instruction
//   id_rs1, id_rs2        forwarded ID operands
//   cnt_clr               synchronous clear of both counters
//   PreWrong              misprediction resolved this cycle
//   flush                 bubble the IF/ID register
//   redirect_pc           recovery PC, 0 unless PreWrong
//   br_cnt, miss_cnt      saturating branch / mispredict counters
module branch_resolve_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             ext_flush,
  input  logic             if_B,
  input  logic             if_BrPre,
  input  logic [XLEN-1:0]  if_pc,
  input  logic             if_rvc,
  input  logic [XLEN-1:0]  if_target,
  input  logic [2:0]       id_funct3,
  input  logic [XLEN-1:0]  id_rs1,
  input  logic [XLEN-1:0]  id_rs2,
  input  logic             cnt_clr,
  output logic             PreWrong,
  output logic             flush,
  output logic [XLEN-1:0]  redirect_pc,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  // ID entry. The branch PC itself is only needed to form the fall-through
  // address, so it is folded into r_fall at capture rather than stored.
  logic            r_v;
  logic            r_pred;
  logic [XLEN-1:0] r_fall;
  logic [XLEN-1:0] r_tgt;
  logic [CNT_W-1:0] r_br_cnt;
  logic [CNT_W-1:0] r_miss_cnt;

  logic [XLEN-1:0] w_if_fall;
  logic            w_eq;
  logic            w_lt;
  logic            w_ltu;
  logic            w_taken;
  logic            w_res;
  logic            w_prewrong;

  // Wraps modulo 2^XLEN by construction.
  assign w_if_fall = if_pc + (if_rvc ? XLEN'(2) : XLEN'(4));

  assign w_eq  = (id_rs1 == id_rs2);
  assign w_lt  = ($signed(id_rs1) < $signed(id_rs2));
  assign w_ltu = (id_rs1 < id_rs2);

  always_comb begin
    w_taken = 1'b0;
    case (id_funct3)
      3'b000:  w_taken = w_eq;
      3'b001:  w_taken = ~w_eq;
      3'b100:  w_taken = w_lt;
      3'b101:  w_taken = ~w_lt;
      3'b110:  w_taken = w_ltu;
      3'b111:  w_taken = ~w_ltu;
      default: w_taken = 1'b0;
    endcase
  end

  // A stalled branch stays pending; it resolves exactly once, in the first
  // non-stall cycle, because the entry is either cleared or reloaded then.
  assign w_res      = r_v & ~stall;
  assign w_prewrong = w_res & (w_taken != r_pred);

  assign PreWrong    = w_prewrong;
  assign flush       = w_prewrong | (ext_flush & ~stall);
  assign redirect_pc = w_prewrong ? (w_taken ? r_tgt : r_fall) : '0;
  assign br_cnt      = r_br_cnt;
  assign miss_cnt    = r_miss_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v    <= 1'b0;
      r_pred <= 1'b0;
      r_fall <= '0;
      r_tgt  <= '0;
    end else if (!stall) begin
      if (w_prewrong | ext_flush) begin
        // Wrong-path (or externally flushed) IF instruction never enters ID.
        r_v <= 1'b0;
      end else begin
        r_v    <= if_B;
        r_pred <= if_BrPre;
        r_fall <= w_if_fall;
        r_tgt  <= if_target;
      end
    end
  end

  // Clear wins over increment and ignores stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_br_cnt   <= '0;
      r_miss_cnt <= '0;
    end else if (cnt_clr) begin
      r_br_cnt   <= '0;
      r_miss_cnt <= '0;
    end else if (w_res) begin
      if (~&r_br_cnt)
        r_br_cnt <= r_br_cnt + CNT_W'(1);
      if (w_prewrong && ~&r_miss_cnt)
        r_miss_cnt <= r_miss_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, stall, ext_flush, if_B, if_BrPre, if_rvc, cnt_clr;
  logic [31:0] if_pc, if_target, id_rs1, id_rs2;
  logic [2:0]  id_funct3;
  logic        PreWrong, flush;
  logic [31:0] redirect_pc;
  logic [15:0] br_cnt, miss_cnt;
  // Narrow-counter instance on the same stimulus, used to reach saturation
  // in a handful of cycles.
  logic        PreWrong_s, flush_s;
  logic [31:0] redirect_pc_s;
  logic [3:0]  br_cnt_s, miss_cnt_s;

  branch_resolve_unit #(.XLEN(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .ext_flush(ext_flush),
    .if_B(if_B), .if_BrPre(if_BrPre), .if_pc(if_pc), .if_rvc(if_rvc),
    .if_target(if_target), .id_funct3(id_funct3), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .cnt_clr(cnt_clr), .PreWrong(PreWrong), .flush(flush),
    .redirect_pc(redirect_pc), .br_cnt(br_cnt), .miss_cnt(miss_cnt));

  branch_resolve_unit #(.XLEN(32), .CNT_W(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .stall(stall), .ext_flush(ext_flush),
    .if_B(if_B), .if_BrPre(if_BrPre), .if_pc(if_pc), .if_rvc(if_rvc),
    .if_target(if_target), .id_funct3(id_funct3), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .cnt_clr(cnt_clr), .PreWrong(PreWrong_s), .flush(flush_s),
    .redirect_pc(redirect_pc_s), .br_cnt(br_cnt_s), .miss_cnt(miss_cnt_s));

  typedef struct {
    logic        pw;
    logic        fl;
    logic [31:0] rpc;
    logic [15:0] br;
    logic [15:0] miss;
  } exp_t;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        pred;
    logic        rvc;
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        taken;
  } vec_t;

  exp_t        sbq[$];
  int          total = 0;
  int          bad   = 0;
  logic [15:0] m_br   = '0;
  logic [15:0] m_miss = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  // Expected outputs for the current cycle go on the queue; the model
  // counters then advance to what the DUT should hold after the edge.
  task automatic push(input logic res, input logic pw, input logic fl,
                      input logic [31:0] rpc, input logic clr);
    exp_t e;
    e.pw = pw; e.fl = fl; e.rpc = rpc; e.br = m_br; e.miss = m_miss;
    sbq.push_back(e);
    if (clr) begin
      m_br = '0; m_miss = '0;
    end else if (res) begin
      if (m_br != 16'hFFFF) m_br++;
      if (pw && m_miss != 16'hFFFF) m_miss++;
    end
  endtask

  task automatic sample(input string tag);
    exp_t e;
    #4;
    if (sbq.size() == 0) begin
      total++; bad++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sbq.pop_front();
      chk({tag, ".PreWrong"},    32'(PreWrong),   32'(e.pw));
      chk({tag, ".flush"},       32'(flush),      32'(e.fl));
      chk({tag, ".redirect_pc"}, redirect_pc,     e.rpc);
      chk({tag, ".br_cnt"},      32'(br_cnt),     32'(e.br));
      chk({tag, ".miss_cnt"},    32'(miss_cnt),   32'(e.miss));
      chk({tag, ".PreWrong_s"},  32'(PreWrong_s), 32'(e.pw));
    end
  endtask

  // Inputs are set by the caller at posedge+1; outputs sampled mid-cycle.
  task automatic cyc(input string tag, input logic res, input logic pw,
                     input logic fl, input logic [31:0] rpc, input logic clr);
    push(res, pw, fl, rpc, clr);
    sample(tag);
    @(posedge clk); #1;
  endtask

  task automatic set_if(input logic b, input logic pred, input logic [31:0] pc,
                        input logic rvc, input logic [31:0] tgt);
    if_B = b; if_BrPre = pred; if_pc = pc; if_rvc = rvc; if_target = tgt;
  endtask

  task automatic set_id(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    id_funct3 = f3; id_rs1 = a; id_rs2 = b;
  endtask

  // One branch: capture in IF, resolve the following cycle.
  task automatic br_pair(input string tag, input vec_t v, input logic clr);
    logic        pw;
    logic [31:0] rpc;
    pw  = (v.taken != v.pred);
    rpc = v.taken ? v.tgt : (v.pc + (v.rvc ? 32'd2 : 32'd4));
    if (!pw) rpc = '0;
    set_if(1'b1, v.pred, v.pc, v.rvc, v.tgt);
    set_id(3'd0, 32'd0, 32'd1);
    cyc({tag, ".load"}, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    set_if(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    set_id(v.f3, v.rs1, v.rs2);
    cnt_clr = clr;
    cyc({tag, ".res"}, 1'b1, pw, pw, rpc, clr);
    cnt_clr = 1'b0;
  endtask

  vec_t tbl[11];

  initial begin
    tbl[0]  = '{3'd0, 32'd5,         32'd6,         1'b1, 1'b0, 32'h100,      32'h200,  1'b0};
    tbl[1]  = '{3'd1, 32'd1,         32'd0,         1'b0, 1'b1, 32'h1FE,      32'h180,  1'b1};
    tbl[2]  = '{3'd4, 32'hFFFFFFFF,  32'd0,         1'b1, 1'b0, 32'h180,      32'h1C0,  1'b1};
    tbl[3]  = '{3'd5, 32'h80000000,  32'd1,         1'b1, 1'b0, 32'h2000,     32'h1000, 1'b0};
    tbl[4]  = '{3'd6, 32'd1,         32'hFFFFFFFF,  1'b0, 1'b0, 32'h3000,     32'h3800, 1'b1};
    tbl[5]  = '{3'd7, 32'd7,         32'd7,         1'b1, 1'b0, 32'h3100,     32'h3200, 1'b1};
    tbl[6]  = '{3'd2, 32'd0,         32'd0,         1'b1, 1'b0, 32'h40,       32'h80,   1'b0};
    tbl[7]  = '{3'd0, 32'd1,         32'd2,         1'b1, 1'b1, 32'hFFFFFFFE, 32'h10,   1'b0};
    tbl[8]  = '{3'd1, 32'd9,         32'd9,         1'b0, 1'b0, 32'h600,      32'h700,  1'b0};
    tbl[9]  = '{3'd5, 32'hFFFFFFF0,  32'hFFFFFFF0,  1'b0, 1'b0, 32'h800,      32'h900,  1'b1};
    tbl[10] = '{3'd4, 32'h80000000,  32'h7FFFFFFF,  1'b0, 1'b1, 32'h9FE,      32'hA00,  1'b1};

    rst_n = 1'b0; stall = 1'b0; ext_flush = 1'b0; cnt_clr = 1'b0;
    set_if(1'b1, 1'b1, 32'h50, 1'b0, 32'h60);
    set_id(3'd1, 32'd1, 32'd2);
    @(posedge clk); #1;
    cyc("reset", 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    cyc("reset2", 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    rst_n = 1'b1;
    set_if(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

    for (int i = 0; i < 10; i++) cyc("idle", 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);

    for (int i = 0; i < 11; i++) br_pair($sformatf("vec%0d", i), tbl[i], 1'b0);

    // Mispredicted BGEU held by stall for 3 cycles, then resolves once.
    set_if(1'b1, 1'b1, 32'h300, 1'b0, 32'h400);
    cyc("stl.load", 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    stall = 1'b1;
    set_id(3'd7, 32'd0, 32'hFFFFFFFF);
    set_if(1'b1, 1'b0, 32'h990, 1'b0, 32'h9A0);
    cyc("stl.hold0", 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    ext_flush = 1'b1;
    cyc("stl.hold1", 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    ext_flush = 1'b0;
    cyc("stl.hold2", 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    stall = 1'b0;
    set_if(1'b1, 1'b0, 32'h700, 1'b0, 32'h800);
    cyc("stl.res", 1'b1, 1'b1, 1'b1, 32'h304, 1'b0);
    set_if(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    set_id(3'd0, 32'd1, 32'd1);
    cyc("stl.squash", 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);

    // Back-to-back: correct BEQ lets the next branch load; that BNE then
    // mispredicts together with ext_flush (single flush).
    set_if(1'b1, 1'b1, 32'h400, 1'b0, 32'h480);
    cyc("b2b.load", 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    set_id(3'd0, 32'd3, 32'd3);
    set_if(1'b1, 1'b0, 32'h500, 1'b1, 32'h600);
    cyc("b2b.ok", 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    set_id(3'd1, 32'd3, 32'd4);
    set_if(1'b1, 1'b0, 32'h502, 1'b0, 32'h5F0);
    ext_flush = 1'b1;
    cyc("b2b.pw_xf", 1'b1, 1'b1, 1'b1, 32'h600, 1'b0);
    ext_flush = 1'b0;
    set_if(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    set_id(3'd0, 32'd1, 32'd1);
    cyc("b2b.after", 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);

    // ext_flush drops the branch being captured.
    set_if(1'b1, 1'b0, 32'h800, 1'b0, 32'h900);
    ext_flush = 1'b1;
    cyc("xf", 1'b0, 1'b0, 1'b1, 32'd0, 1'b0);
    ext_flush = 1'b0;
    set_if(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    set_id(3'd0, 32'd1, 32'd1);
    cyc("xf.clr", 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);

    // Clear together with a resolving mispredict.
    br_pair("clr_res", tbl[0], 1'b1);

    // Saturation on the 4-bit instance: 14 mispredicts reach 0xE, 3 more stop at 0xF.
    for (int i = 0; i < 14; i++) br_pair("sat", tbl[0], 1'b0);
    chk("sat.br_cnt_s.E",   32'(br_cnt_s),   32'hE);
    chk("sat.miss_cnt_s.E", 32'(miss_cnt_s), 32'hE);
    for (int i = 0; i < 3; i++) br_pair("sat", tbl[0], 1'b0);
    chk("sat.br_cnt_s.F",   32'(br_cnt_s),   32'hF);
    chk("sat.miss_cnt_s.F", 32'(miss_cnt_s), 32'hF);

    // Clear applies even while stalled.
    stall = 1'b1; cnt_clr = 1'b1;
    cyc("clr_stall", 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    stall = 1'b0; cnt_clr = 1'b0;
    cyc("clr_after", 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    chk("clr.br_cnt_s", 32'(br_cnt_s), 32'h0);

    // Reset during the resolve cycle drops the branch.
    br_pair("pre_rst", tbl[2], 1'b0);
    set_if(1'b1, 1'b1, 32'hA00, 1'b0, 32'hB00);
    cyc("rst_mid.load", 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    set_if(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    set_id(3'd0, 32'd1, 32'd2);
    rst_n = 1'b0;
    m_br = '0; m_miss = '0;
    cyc("rst_mid", 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    rst_n = 1'b1;
    cyc("rst_mid.after", 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
